// File: rtl/reorder_buffer_pkg.sv
// Shared processor types for the reorder buffer, issue and functional units.
// Entry metadata record and default sizing.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic       valid;
        logic       done;
        logic [4:0] rd;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// Wrap-bit circular pointer: TAG_W index bits plus one wrap bit.
// Counts modulo 2*DEPTH; clear returns it to zero.
module rob_ptr #(
    parameter int TAG_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           inc,
    output logic [TAG_W:0] ptr
);

    // Clear wins over increment; natural overflow wraps modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (rst || clr)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + 1'b1;
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, complete out of order,
// commit one entry per cycle from head into the register file.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = ROB_DEPTH,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_rd,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             cmpl_valid,
    input  logic [TAG_W-1:0] cmpl_tag,
    input  logic [WIDTH-1:0] cmpl_data,
    input  logic             flush,
    output logic             commit_w_en,
    output logic [4:0]       commit_rd_addr,
    output logic [WIDTH-1:0] commit_w_data,
    output logic [TAG_W:0]   count,
    output logic             empty
);

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    rob_entry_t       meta [DEPTH];
    logic [WIDTH-1:0] data [DEPTH];

    logic [TAG_W:0]   head;
    logic [TAG_W:0]   tail;
    logic [TAG_W-1:0] head_idx;
    logic             alloc_fire;
    logic             cmpl_fire;
    logic             commit_fire;
    logic             kill;

    assign kill     = rst | flush;
    assign head_idx = head[TAG_W-1:0];

    assign alloc_ready = (count != FULL_CNT);
    assign alloc_tag   = tail[TAG_W-1:0];
    assign empty       = (count == '0);

    assign alloc_fire  = alloc_valid & alloc_ready & ~kill;
    assign cmpl_fire   = cmpl_valid & meta[cmpl_tag].valid
                       & ~meta[cmpl_tag].done & ~kill;
    assign commit_fire = meta[head_idx].valid & meta[head_idx].done & ~kill;

    assign commit_w_en    = commit_fire & (meta[head_idx].rd != 5'd0);
    assign commit_rd_addr = meta[head_idx].rd;
    assign commit_w_data  = data[head_idx];

    rob_ptr #(.TAG_W(TAG_W)) u_head (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (commit_fire),
        .ptr (head)
    );

    rob_ptr #(.TAG_W(TAG_W)) u_tail (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (alloc_fire),
        .ptr (tail)
    );

    // Entry status: allocate at tail, mark done on completion, retire at head.
    always_ff @(posedge clk) begin
        if (kill) begin
            for (int i = 0; i < DEPTH; i++) begin
                meta[i].valid <= 1'b0;
                meta[i].done  <= 1'b0;
            end
        end else begin
            if (alloc_fire) begin
                meta[alloc_tag].valid <= 1'b1;
                meta[alloc_tag].done  <= 1'b0;
                meta[alloc_tag].rd    <= alloc_rd;
            end
            if (cmpl_fire)
                meta[cmpl_tag].done <= 1'b1;
            if (commit_fire) begin
                meta[head_idx].valid <= 1'b0;
                meta[head_idx].done  <= 1'b0;
            end
        end
    end

    // Result payload needs no reset; it is only read once done is set.
    always_ff @(posedge clk) begin
        if (cmpl_fire)
            data[cmpl_tag] <= cmpl_data;
    end

    // Occupancy tracks net allocations minus retirements.
    always_ff @(posedge clk) begin
        if (kill)
            count <= '0;
        else
            count <= count + {{TAG_W{1'b0}}, alloc_fire}
                           - {{TAG_W{1'b0}}, commit_fire};
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: in-order commit, full, x0, flush,
// duplicate completions and mid-operation reset.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        cmpl_valid;
    logic [2:0]  cmpl_tag;
    logic [31:0] cmpl_data;
    logic        flush;
    logic        commit_w_en;
    logic [4:0]  commit_rd_addr;
    logic [31:0] commit_w_data;
    logic [3:0]  count;
    logic        empty;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reorder_buffer #(.WIDTH(32), .DEPTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_rd       (alloc_rd),
        .alloc_ready    (alloc_ready),
        .alloc_tag      (alloc_tag),
        .cmpl_valid     (cmpl_valid),
        .cmpl_tag       (cmpl_tag),
        .cmpl_data      (cmpl_data),
        .flush          (flush),
        .commit_w_en    (commit_w_en),
        .commit_rd_addr (commit_rd_addr),
        .commit_w_data  (commit_w_data),
        .count          (count),
        .empty          (empty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic commit_chk(input string tag, input logic en,
                              input logic [4:0] rd, input logic [31:0] d);
        chk({tag, "_en"}, 32'(commit_w_en), 32'(en));
        if (en) begin
            chk({tag, "_rd"}, 32'(commit_rd_addr), 32'(rd));
            chk({tag, "_data"}, commit_w_data, d);
        end
    endtask

    initial begin
        rst = 1'b1; alloc_valid = 1'b0; alloc_rd = '0;
        cmpl_valid = 1'b0; cmpl_tag = '0; cmpl_data = '0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        settle();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ready", 32'(alloc_ready), 1);
        chk("rst_tag", 32'(alloc_tag), 0);
        chk("rst_wen", 32'(commit_w_en), 0);

        // In-order retirement of out-of-order completions.
        alloc_valid = 1'b1; alloc_rd = 5'd5; settle();
        chk("a5_tag", 32'(alloc_tag), 0);
        tick(); alloc_rd = 5'd6; settle();
        chk("a6_tag", 32'(alloc_tag), 1);
        tick(); alloc_rd = 5'd7; settle();
        chk("a7_tag", 32'(alloc_tag), 2);
        tick(); alloc_valid = 1'b0; settle();
        chk("ooo_count", 32'(count), 3);
        cmpl_valid = 1'b1; cmpl_tag = 3'd2; cmpl_data = 32'hC; settle();
        commit_chk("c2", 1'b0, 5'd0, 32'h0);
        tick(); cmpl_tag = 3'd0; cmpl_data = 32'hA; settle();
        commit_chk("c0_nobypass", 1'b0, 5'd0, 32'h0);
        tick(); cmpl_tag = 3'd1; cmpl_data = 32'hB; settle();
        commit_chk("commit_x5", 1'b1, 5'd5, 32'hA);
        tick(); cmpl_valid = 1'b0; settle();
        commit_chk("commit_x6", 1'b1, 5'd6, 32'hB);
        tick(); settle();
        commit_chk("commit_x7", 1'b1, 5'd7, 32'hC);
        tick(); settle();
        commit_chk("ooo_idle", 1'b0, 5'd0, 32'h0);
        chk("ooo_empty", 32'(empty), 1);

        // Fill to capacity from tag 0.
        flush = 1'b1; tick(); flush = 1'b0;
        alloc_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            alloc_rd = 5'(8 + i);
            tick();
        end
        alloc_rd = 5'd20; settle();
        chk("full_count", 32'(count), 8);
        chk("full_ready", 32'(alloc_ready), 0);
        chk("full_tag", 32'(alloc_tag), 0);
        cmpl_valid = 1'b1; cmpl_tag = 3'd0; cmpl_data = 32'h100;
        tick(); cmpl_valid = 1'b0; settle();
        chk("full_blocked", 32'(count), 8);
        commit_chk("full_commit", 1'b1, 5'd8, 32'h100);
        chk("full_ready_same", 32'(alloc_ready), 0);
        tick(); settle();
        chk("full_after_cnt", 32'(count), 7);
        chk("full_after_ready", 32'(alloc_ready), 1);
        chk("full_wrap_tag", 32'(alloc_tag), 0);
        tick(); alloc_valid = 1'b0; settle();
        chk("refill_count", 32'(count), 8);
        chk("refill_ready", 32'(alloc_ready), 0);

        // x0 destination retires silently.
        flush = 1'b1; tick(); flush = 1'b0;
        alloc_valid = 1'b1; alloc_rd = 5'd0;
        tick(); alloc_valid = 1'b0;
        cmpl_valid = 1'b1; cmpl_tag = 3'd0; cmpl_data = 32'hFFFF;
        tick(); cmpl_valid = 1'b0; settle();
        chk("x0_wen", 32'(commit_w_en), 0);
        chk("x0_count_pre", 32'(count), 1);
        tick(); settle();
        chk("x0_count", 32'(count), 0);
        chk("x0_empty", 32'(empty), 1);

        // Duplicate and stale completions are ignored (head=1).
        alloc_valid = 1'b1; alloc_rd = 5'd9; tick();
        alloc_rd = 5'd10; tick(); alloc_valid = 1'b0;
        cmpl_valid = 1'b1; cmpl_tag = 3'd2; cmpl_data = 32'h55; tick();
        cmpl_data = 32'h1234; tick();
        cmpl_tag = 3'd5; cmpl_data = 32'h777; settle();
        commit_chk("dup_idle", 1'b0, 5'd0, 32'h0);
        tick(); cmpl_tag = 3'd1; cmpl_data = 32'h66; settle();
        chk("free_cmpl_count", 32'(count), 2);
        commit_chk("free_cmpl_idle", 1'b0, 5'd0, 32'h0);
        tick(); cmpl_valid = 1'b0; settle();
        commit_chk("dup_x9", 1'b1, 5'd9, 32'h66);
        tick(); settle();
        commit_chk("dup_x10", 1'b1, 5'd10, 32'h55);
        tick(); settle();
        chk("dup_empty", 32'(empty), 1);

        // Flush while head is committable (head=3).
        alloc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alloc_rd = 5'(11 + i);
            tick();
        end
        alloc_valid = 1'b0;
        cmpl_valid = 1'b1; cmpl_tag = 3'd4; cmpl_data = 32'h44; tick();
        cmpl_tag = 3'd3; cmpl_data = 32'h33; tick();
        cmpl_valid = 1'b0; settle();
        commit_chk("pre_flush", 1'b1, 5'd11, 32'h33);
        flush = 1'b1; settle();
        chk("flush_wen", 32'(commit_w_en), 0);
        tick(); flush = 1'b0; settle();
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_tag", 32'(alloc_tag), 0);
        chk("flush_idle", 32'(commit_w_en), 0);

        // Reset mid-operation with simultaneous alloc and completion.
        alloc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alloc_rd = 5'(1 + i);
            tick();
        end
        cmpl_valid = 1'b1; cmpl_tag = 3'd0; cmpl_data = 32'h10; tick();
        alloc_rd = 5'd4; cmpl_tag = 3'd1; cmpl_data = 32'h99; rst = 1'b1;
        tick();
        rst = 1'b0; alloc_valid = 1'b0; cmpl_valid = 1'b0; settle();
        chk("mrst_count", 32'(count), 0);
        chk("mrst_empty", 32'(empty), 1);
        chk("mrst_ready", 32'(alloc_ready), 1);
        chk("mrst_tag", 32'(alloc_tag), 0);
        chk("mrst_wen", 32'(commit_w_en), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
